// File: rtl/trig_rate_scaler_pkg.sv
// Shared widths and state encoding for the trigger rate scaler slice.
package trig_rate_scaler_pkg;

  // Default widths; the interval width holds one second of CLK120 cycles.
  localparam int TRIG_COUNT_WIDTH    = 24;
  localparam int TRIG_DEAD_WIDTH     = 8;
  localparam int TRIG_INTERVAL_WIDTH = 27;

  // Dead-time FSM states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DEAD = 1'b1
  } dead_state_e;

endpackage

// File: rtl/trig_dead_time.sv
// Dead-time filter: accepts a trigger from IDLE, then rejects pulses for
// DEAD_TIME cycles. Produces the combinational accept strobe for the counter
// logic plus registered TRIG_OUT and BUSY.
module trig_dead_time
  import trig_rate_scaler_pkg::*;
#(
  parameter int DEAD_WIDTH = TRIG_DEAD_WIDTH
) (
  input  logic                  CLK120,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic                  TRIG_IN,
  input  logic [DEAD_WIDTH-1:0] DEAD_TIME,
  output logic                  accept,
  output logic                  TRIG_OUT,
  output logic                  BUSY
);

  localparam logic [DEAD_WIDTH-1:0] DEAD_ONE = {{(DEAD_WIDTH-1){1'b0}}, 1'b1};

  dead_state_e           state_r;
  dead_state_e           state_s;
  logic [DEAD_WIDTH-1:0] dead_cnt_r;
  logic [DEAD_WIDTH-1:0] dead_cnt_s;
  logic                  accept_s;
  logic                  trig_out_r;
  logic                  busy_r;

  // Next-state logic: disable forces IDLE; DEAD_TIME is only sampled at acceptance.
  always_comb begin
    state_s    = state_r;
    dead_cnt_s = dead_cnt_r;
    accept_s   = 1'b0;
    if (!ENABLE) begin
      state_s    = ST_IDLE;
      dead_cnt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (TRIG_IN) begin
            accept_s   = 1'b1;
            dead_cnt_s = DEAD_TIME;
            if (DEAD_TIME != '0) begin
              state_s = ST_DEAD;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DEAD: begin
          dead_cnt_s = dead_cnt_r - DEAD_ONE;
          if (dead_cnt_r == DEAD_ONE) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DEAD;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          dead_cnt_s = '0;
        end
      endcase
    end
  end

  // State, dead counter and registered outputs; BUSY mirrors the DEAD state.
  always_ff @(posedge CLK120 or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      dead_cnt_r <= '0;
      trig_out_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      dead_cnt_r <= dead_cnt_s;
      trig_out_r <= accept_s;
      busy_r     <= (state_s == ST_DEAD);
    end
  end

  assign accept   = accept_s;
  assign TRIG_OUT = trig_out_r;
  assign BUSY     = busy_r;

endmodule

// File: rtl/trig_rate_scaler_chk.sv
// Invariant checks on the scaler outputs; no functional logic.
module trig_rate_scaler_chk (
  input logic CLK120,
  input logic RST_N,
  input logic ENABLE,
  input logic TRIG_OUT,
  input logic BUSY,
  input logic OVERRUN
);

  logic enable_d_r;
  logic overrun_d_r;

  // Previous-cycle copies of ENABLE and OVERRUN for the one-cycle-lag checks.
  always_ff @(posedge CLK120 or negedge RST_N) begin
    if (!RST_N) begin
      enable_d_r  <= 1'b0;
      overrun_d_r <= 1'b0;
    end else begin
      enable_d_r  <= ENABLE;
      overrun_d_r <= OVERRUN;
    end
  end

  // A disabled cycle can never be followed by a trigger or dead time; OVERRUN is sticky.
  always @(posedge CLK120) begin
    if (RST_N) begin
      assert (enable_d_r || !TRIG_OUT);
      assert (enable_d_r || !BUSY);
      assert (!overrun_d_r || OVERRUN);
    end
  end

endmodule

// File: rtl/trig_rate_scaler.sv
// Trigger rate scaler: dead-time filtering, per-interval counting of accepted
// triggers and a valid/ack handoff of each interval's count.
module trig_rate_scaler
  import trig_rate_scaler_pkg::*;
#(
  parameter int COUNT_WIDTH    = TRIG_COUNT_WIDTH,
  parameter int DEAD_WIDTH     = TRIG_DEAD_WIDTH,
  parameter int INTERVAL_WIDTH = TRIG_INTERVAL_WIDTH
) (
  input  logic                      CLK120,
  input  logic                      RST_N,
  input  logic                      ENABLE,
  input  logic                      TRIG_IN,
  input  logic [DEAD_WIDTH-1:0]     DEAD_TIME,
  input  logic [INTERVAL_WIDTH-1:0] INTERVAL,
  input  logic                      COUNT_ACK,
  output logic                      TRIG_OUT,
  output logic                      BUSY,
  output logic [COUNT_WIDTH-1:0]    COUNT,
  output logic                      COUNT_VALID,
  output logic                      SATURATED,
  output logic                      OVERRUN
);

  localparam logic [COUNT_WIDTH-1:0]    CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0]    CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INTERVAL_WIDTH-1:0] IVL_ONE = {{(INTERVAL_WIDTH-1){1'b0}}, 1'b1};

  logic                      accept_s;
  logic [COUNT_WIDTH-1:0]    run_cnt_r;
  logic [COUNT_WIDTH-1:0]    run_cnt_s;
  logic                      run_sat_r;
  logic                      run_sat_s;
  logic [INTERVAL_WIDTH-1:0] ivl_cnt_r;
  logic [INTERVAL_WIDTH-1:0] ivl_cnt_s;
  logic                      terminal_s;
  logic [COUNT_WIDTH-1:0]    count_r;
  logic                      valid_r;
  logic                      sat_r;
  logic                      overrun_r;

  trig_dead_time #(
    .DEAD_WIDTH (DEAD_WIDTH)
  ) u_dead_time (
    .CLK120    (CLK120),
    .RST_N     (RST_N),
    .ENABLE    (ENABLE),
    .TRIG_IN   (TRIG_IN),
    .DEAD_TIME (DEAD_TIME),
    .accept    (accept_s),
    .TRIG_OUT  (TRIG_OUT),
    .BUSY      (BUSY)
  );

  // Saturating running count including this cycle's acceptance, and its sticky flag.
  always_comb begin
    run_cnt_s = run_cnt_r;
    if (accept_s && (run_cnt_r != CNT_MAX)) begin
      run_cnt_s = run_cnt_r + CNT_ONE;
    end else begin
      run_cnt_s = run_cnt_r;
    end
    run_sat_s = run_sat_r | (run_cnt_s == CNT_MAX);
  end

  // Gate position and terminal-cycle detect; a zero INTERVAL disables gating.
  always_comb begin
    ivl_cnt_s  = ivl_cnt_r;
    terminal_s = 1'b0;
    if (INTERVAL == '0) begin
      ivl_cnt_s  = '0;
      terminal_s = 1'b0;
    end else begin
      ivl_cnt_s  = ivl_cnt_r + IVL_ONE;
      terminal_s = ENABLE && (ivl_cnt_r == (INTERVAL - IVL_ONE));
    end
  end

  // Interval, running count and saturation flag: cleared while disabled and at each terminal cycle.
  always_ff @(posedge CLK120 or negedge RST_N) begin
    if (!RST_N) begin
      run_cnt_r <= '0;
      run_sat_r <= 1'b0;
      ivl_cnt_r <= '0;
    end else if (!ENABLE || terminal_s) begin
      run_cnt_r <= '0;
      run_sat_r <= 1'b0;
      ivl_cnt_r <= '0;
    end else begin
      run_cnt_r <= run_cnt_s;
      run_sat_r <= run_sat_s;
      ivl_cnt_r <= ivl_cnt_s;
    end
  end

  // Latch and handshake: a latch beats a coincident ack; an unacked overwrite sets OVERRUN.
  always_ff @(posedge CLK120 or negedge RST_N) begin
    if (!RST_N) begin
      count_r   <= '0;
      valid_r   <= 1'b0;
      sat_r     <= 1'b0;
      overrun_r <= 1'b0;
    end else if (terminal_s) begin
      count_r   <= run_cnt_s;
      sat_r     <= run_sat_s;
      valid_r   <= 1'b1;
      overrun_r <= overrun_r | (valid_r & ~COUNT_ACK);
    end else if (COUNT_ACK && valid_r) begin
      valid_r   <= 1'b0;
    end else begin
      valid_r   <= valid_r;
    end
  end

  trig_rate_scaler_chk u_chk (
    .CLK120   (CLK120),
    .RST_N    (RST_N),
    .ENABLE   (ENABLE),
    .TRIG_OUT (TRIG_OUT),
    .BUSY     (BUSY),
    .OVERRUN  (overrun_r)
  );

  assign COUNT       = count_r;
  assign COUNT_VALID = valid_r;
  assign SATURATED   = sat_r;
  assign OVERRUN     = overrun_r;

endmodule

// File: tb/tb_trig_rate_scaler.sv
// Self-checking bench: directed scenarios with literal expectations, then
// random stimulus against a cycle-count based behavioural model. Two DUTs
// share the stimulus: the default build and a 4-bit count build.
module tb_trig_rate_scaler;

  localparam int CW = 24;
  localparam int DW = 8;
  localparam int IW = 27;

  logic          CLK120 = 1'b0;
  logic          RST_N;
  logic          ENABLE;
  logic          TRIG_IN;
  logic [DW-1:0] DEAD_TIME;
  logic [IW-1:0] INTERVAL;
  logic          COUNT_ACK;

  logic          trig_out_a, busy_a, valid_a, sat_a, ovr_a;
  logic [CW-1:0] count_a;
  logic          trig_out_b, busy_b, valid_b, sat_b, ovr_b;
  logic [3:0]    count_b;

  always #4 CLK120 = ~CLK120;

  trig_rate_scaler dut_a (
    .CLK120(CLK120), .RST_N(RST_N), .ENABLE(ENABLE), .TRIG_IN(TRIG_IN),
    .DEAD_TIME(DEAD_TIME), .INTERVAL(INTERVAL), .COUNT_ACK(COUNT_ACK),
    .TRIG_OUT(trig_out_a), .BUSY(busy_a), .COUNT(count_a),
    .COUNT_VALID(valid_a), .SATURATED(sat_a), .OVERRUN(ovr_a)
  );

  trig_rate_scaler #(.COUNT_WIDTH(4)) dut_b (
    .CLK120(CLK120), .RST_N(RST_N), .ENABLE(ENABLE), .TRIG_IN(TRIG_IN),
    .DEAD_TIME(DEAD_TIME), .INTERVAL(INTERVAL), .COUNT_ACK(COUNT_ACK),
    .TRIG_OUT(trig_out_b), .BUSY(busy_b), .COUNT(count_b),
    .COUNT_VALID(valid_b), .SATURATED(sat_b), .OVERRUN(ovr_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Behavioural model: absolute cycle numbers and an unbounded acceptance count.
  longint cyc;
  longint free_at;
  longint m_cnt;
  longint m_pos;
  longint cmax [2];
  longint m_count [2];
  bit     m_sat [2];
  bit     m_tout, m_busy, m_valid, m_ovr;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    free_at = 0;
    m_cnt   = 0;
    m_pos   = 0;
    m_tout  = 1'b0;
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0;
      m_sat[i]   = 1'b0;
    end
  endtask

  task automatic model_step();
    bit acc;
    bit latch;
    if (!RST_N) begin
      model_reset();
    end else begin
      acc = ENABLE && TRIG_IN && (cyc >= free_at);
      if (!ENABLE) free_at = cyc + 1;
      else if (acc) free_at = cyc + 1 + longint'(DEAD_TIME);
      m_tout = acc;
      m_busy = (cyc + 1 < free_at);
      latch = 1'b0;
      if (!ENABLE) begin
        m_cnt = 0;
        m_pos = 0;
      end else begin
        m_cnt = m_cnt + (acc ? 1 : 0);
        if (INTERVAL != '0 && m_pos == longint'(INTERVAL) - 1) latch = 1'b1;
        else if (INTERVAL == '0) m_pos = 0;
        else m_pos = (m_pos + 1) % (64'd1 << IW);
      end
      if (latch) begin
        if (m_valid && !COUNT_ACK) m_ovr = 1'b1;
        m_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
          m_count[i] = (m_cnt < cmax[i]) ? m_cnt : cmax[i];
          m_sat[i]   = (m_cnt >= cmax[i]);
        end
        m_cnt = 0;
        m_pos = 0;
      end else if (COUNT_ACK) begin
        m_valid = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge CLK120);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of both DUTs against the model, away from the active edge.
  always @(negedge CLK120) begin
    if (chk_on) begin
      cmp("trig_out_a", trig_out_a, m_tout);
      cmp("busy_a", busy_a, m_busy);
      cmp("count_a", count_a, m_count[0]);
      cmp("valid_a", valid_a, m_valid);
      cmp("sat_a", sat_a, m_sat[0]);
      cmp("overrun_a", ovr_a, m_ovr);
      cmp("trig_out_b", trig_out_b, m_tout);
      cmp("busy_b", busy_b, m_busy);
      cmp("count_b", count_b, m_count[1]);
      cmp("valid_b", valid_b, m_valid);
      cmp("sat_b", sat_b, m_sat[1]);
      cmp("overrun_b", ovr_b, m_ovr);
    end
  end

  task automatic check_all_zero(input string tag);
    cmp({tag, "_trig_out"}, {trig_out_a, trig_out_b}, 2'b00);
    cmp({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
    cmp({tag, "_count_a"}, count_a, 24'd0);
    cmp({tag, "_count_b"}, count_b, 4'd0);
    cmp({tag, "_valid"}, {valid_a, valid_b}, 2'b00);
    cmp({tag, "_sat"}, {sat_a, sat_b}, 2'b00);
    cmp({tag, "_overrun"}, {ovr_a, ovr_b}, 2'b00);
  endtask

  initial begin
    logic [31:0] tout_mask;
    logic [31:0] busy_mask;
    int          n_out;
    bit          any_busy;
    int          trig_pct;

    cmax[0] = (64'd1 << CW) - 1;
    cmax[1] = 64'd15;
    cyc = 0;
    model_reset();
    RST_N = 1'b1; ENABLE = 1'b0; TRIG_IN = 1'b0; COUNT_ACK = 1'b0;
    DEAD_TIME = 8'd0; INTERVAL = 27'd0;
    #2 RST_N = 1'b0;
    #1;
    chk_on = 1'b1;
    check_all_zero("reset");
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Dead time 3, pulses at 10,11,13,14,15.
    ENABLE = 1'b1; DEAD_TIME = 8'd3; INTERVAL = 27'd0;
    tout_mask = 32'd0; busy_mask = 32'd0;
    for (int k = 0; k < 20; k++) begin
      TRIG_IN = (k == 10 || k == 11 || k == 13 || k == 14 || k == 15);
      tick();
      tout_mask[k+1] = trig_out_a;
      busy_mask[k+1] = busy_a;
    end
    TRIG_IN = 1'b0;
    cmp("dt3_trig_out_cycles", tout_mask, 32'h0000_8800);
    cmp("dt3_busy_cycles", busy_mask & 32'h0000_7FFF, 32'h0000_3800);

    // Dead time 0, five back-to-back pulses.
    DEAD_TIME = 8'd0; n_out = 0; any_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      TRIG_IN = (k < 5);
      tick();
      n_out = n_out + int'(trig_out_a);
      any_busy = any_busy | busy_a;
    end
    TRIG_IN = 1'b0;
    cmp("dt0_pulse_count", n_out, 32'd5);
    cmp("dt0_busy_never", any_busy, 1'b0);

    // Interval 100, 7 pulses including one in the terminal cycle.
    ENABLE = 1'b0; tick();
    INTERVAL = 27'd100; ENABLE = 1'b1;
    for (int k = 0; k < 100; k++) begin
      TRIG_IN = (k == 3 || k == 20 || k == 40 || k == 41 || k == 60 || k == 80 || k == 99);
      tick();
      if (k == 98) cmp("ivl100_valid_before", valid_a, 1'b0);
    end
    cmp("ivl100_count", count_a, 24'd7);
    cmp("ivl100_valid", valid_a, 1'b1);
    cmp("model_ivl100_count", m_count[0], 64'd7);
    for (int k = 100; k < 200; k++) begin
      TRIG_IN = (k == 150 || k == 160);
      COUNT_ACK = (k == 100);
      tick();
      if (k == 100) cmp("ivl100_ack_clears", valid_a, 1'b0);
    end
    TRIG_IN = 1'b0; COUNT_ACK = 1'b0;
    cmp("ivl100_second_count", count_a, 24'd2);
    cmp("ivl100_second_overrun", ovr_a, 1'b0);

    // Interval 50: ack coincident with second latch, then unacked overwrite.
    ENABLE = 1'b0; COUNT_ACK = 1'b1; tick();
    COUNT_ACK = 1'b0; INTERVAL = 27'd50; ENABLE = 1'b1;
    for (int k = 0; k < 100; k++) begin
      TRIG_IN = (k == 5 || k == 30 || k == 60 || k == 61 || k == 70 || k == 98);
      COUNT_ACK = (k == 99);
      tick();
      if (k == 49) cmp("ivl50_first_count", count_a, 24'd2);
    end
    cmp("ivl50_ack_latch_count", count_a, 24'd4);
    cmp("ivl50_ack_latch_valid", valid_a, 1'b1);
    cmp("ivl50_ack_latch_overrun", ovr_a, 1'b0);
    for (int k = 100; k < 200; k++) begin
      TRIG_IN = (k == 110 || k == 120 || k == 150 || k == 151 || k == 152 || k == 190);
      COUNT_ACK = 1'b0;
      tick();
    end
    TRIG_IN = 1'b0;
    cmp("ivl50_noack_count", count_a, 24'd4);
    cmp("ivl50_noack_overrun", ovr_a, 1'b1);
    cmp("model_noack_overrun", m_ovr, 1'b1);

    // Saturation in the 4-bit build: 20 pulses in a 40-cycle interval.
    ENABLE = 1'b0; COUNT_ACK = 1'b1; tick();
    COUNT_ACK = 1'b0; INTERVAL = 27'd40; DEAD_TIME = 8'd0; ENABLE = 1'b1;
    for (int k = 0; k < 40; k++) begin
      TRIG_IN = (k < 20);
      tick();
    end
    TRIG_IN = 1'b0;
    cmp("sat4_count", count_b, 4'd15);
    cmp("sat4_flag", sat_b, 1'b1);
    cmp("sat24_count", count_a, 24'd20);
    cmp("sat24_flag", sat_a, 1'b0);

    // Asynchronous reset in the middle of a dead window with a valid count pending.
    DEAD_TIME = 8'd200; TRIG_IN = 1'b1; tick();
    TRIG_IN = 1'b0; tick(); tick();
    cmp("pre_reset_busy", busy_a, 1'b1);
    cmp("pre_reset_valid", valid_a, 1'b1);
    #1 RST_N = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    tick(); tick();
    RST_N = 1'b1; DEAD_TIME = 8'd5; TRIG_IN = 1'b1;
    tick();
    TRIG_IN = 1'b0;
    cmp("post_reset_accept", trig_out_a, 1'b1);
    tick();

    // Random traffic; INTERVAL only changes while disabled.
    trig_pct = 30;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) ENABLE = ~ENABLE;
      if (!ENABLE && $urandom_range(0, 3) == 0) begin
        INTERVAL = ($urandom_range(0, 9) == 0) ? 27'd0 : IW'($urandom_range(1, 60));
        trig_pct = $urandom_range(10, 90);
      end
      DEAD_TIME = ($urandom_range(0, 3) == 0) ? 8'd0 : DW'($urandom_range(1, 9));
      TRIG_IN = ($urandom_range(0, 99) < trig_pct);
      COUNT_ACK = ($urandom_range(0, 7) == 0);
      if (i == 2000) begin
        #1 RST_N = 1'b0;
        model_reset();
        tick();
        RST_N = 1'b1;
      end
      tick();
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trig_rate_scaler.md
Name: trig_rate_scaler

Overview:
- Consumer end of the single-cycle trigger pulses produced by the SDE trigger blocks, such as the 40 MHz compatibility single-bin trigger. All logic runs in the CLK120 domain.
- Applies a programmable dead time to incoming pulses and forwards accepted triggers.
- Counts accepted triggers over a programmable gate interval.
- Hands each interval's count to the processor-side register logic through a valid/ack handshake.

Parameters:
COUNT_WIDTH, 24, width of running and latched trigger counts
DEAD_WIDTH, 8, width of dead-time setting in CLK120 cycles
INTERVAL_WIDTH, 27, width of gate interval setting in CLK120 cycles (120e6 fits)

Ports:
CLK120  in  1  120 MHz system clock
RST_N  in  1  asynchronous active-low reset
ENABLE  in  1  scaler enable, level
TRIG_IN  in  1  trigger pulse from trigger block, 1 cycle per trigger
DEAD_TIME  in  DEAD_WIDTH  rejection window after an accepted trigger, cycles
INTERVAL  in  INTERVAL_WIDTH  gate length in cycles; 0 = gating disabled
COUNT_ACK  in  1  processor acknowledge of latched count, 1-cycle pulse
TRIG_OUT  out  1  accepted trigger, 1-cycle pulse
BUSY  out  1  high while in dead time
COUNT  out  COUNT_WIDTH  latched count of last completed interval
COUNT_VALID  out  1  latched count not yet acknowledged
SATURATED  out  1  latched count hit all-ones during its interval
OVERRUN  out  1  sticky: a latched count was overwritten unacknowledged

Behaviour:
- Reset (RST_N low, async):
  - All outputs go to 0: TRIG_OUT, BUSY, COUNT, COUNT_VALID, SATURATED, OVERRUN.
  - Internal dead counter, interval counter and running counter go to 0.
  - FSM goes to IDLE.
- Dead-time FSM, states IDLE and DEAD:
  - IDLE, with TRIG_IN=1 and ENABLE=1 at cycle n: trigger accepted. TRIG_OUT=1 in cycle n+1 (latency 1). Dead counter loads DEAD_TIME. Next state is DEAD if DEAD_TIME!=0, else stays IDLE.
  - DEAD: dead counter decrements each cycle; TRIG_IN is ignored; BUSY=1. When the counter reaches 1 and decrements, next state is IDLE.
  - Net effect: pulses at n+1..n+DEAD_TIME are rejected and a pulse at n+DEAD_TIME+1 is accepted. DEAD_TIME=0 accepts back-to-back pulses.
  - DEAD_TIME is sampled only at acceptance; changes during DEAD do not affect the current window.
- Running counter:
  - Increments by 1 on each acceptance.
  - Saturates at all-ones; a saturation flag is set when it reaches all-ones.
- Interval counter:
  - Runs while ENABLE=1 and INTERVAL!=0, counting 0..INTERVAL-1.
  - Terminal cycle is count = INTERVAL-1. In the terminal cycle:
    - COUNT is loaded with the running count, including an acceptance in that same cycle.
    - SATURATED is loaded with the saturation flag.
    - Running counter, saturation flag and interval counter clear to 0.
    - COUNT_VALID is set to 1.
  - INTERVAL is changed only while ENABLE=0; if it is changed while running, the terminal compare uses the new value and a wrap past it continues to all-ones then 0. No recovery beyond that is required.
- Handshake:
  - COUNT_ACK with COUNT_VALID=1 clears COUNT_VALID next cycle.
  - COUNT_ACK with COUNT_VALID=0 is ignored.
  - Latch and COUNT_ACK in the same cycle: the latch wins. COUNT_VALID stays 1 with the new COUNT, and OVERRUN is not set.
  - Latch while COUNT_VALID=1 with no ACK: COUNT is overwritten and OVERRUN is set. OVERRUN stays set until reset.
- ENABLE=0:
  - No acceptance; TRIG_OUT is 0.
  - FSM forced to IDLE; BUSY=0.
  - Interval counter, running counter and saturation flag are cleared.
  - COUNT, COUNT_VALID, SATURATED and OVERRUN hold; the handshake still works.
  - On ENABLE rising, the first interval starts from 0 that cycle.
- Reset mid-interval discards the partial count; no latch occurs.

Decomposition:
- sde_trigger_defs.vh gains the default widths as defines: TRIG_COUNT_WIDTH, TRIG_DEAD_WIDTH, TRIG_INTERVAL_WIDTH.
- One sub-module is natural: trig_dead_time, containing the IDLE/DEAD FSM, dead counter, TRIG_OUT and BUSY. It outputs the accept strobe to the counting/handshake logic in the top module.

Test Plan:
- DEAD_TIME=3, ENABLE=1, TRIG_IN pulses at cycles 10,11,13,14,15: TRIG_OUT at 11 and 15 only. BUSY high cycles 11-13.
- DEAD_TIME=0, TRIG_IN high for 5 consecutive cycles: 5 TRIG_OUT pulses, BUSY never high.
- INTERVAL=100, DEAD_TIME=0, 7 pulses in the first interval, 1 of them in its terminal cycle 99: COUNT=7 and COUNT_VALID=1 at cycle 100. Next interval's count starts at 0.
- INTERVAL=50, no ACK across two terminal cycles with 2 then 4 pulses: COUNT=4, OVERRUN=1. ACK coincident with the second latch instead: COUNT=4, COUNT_VALID=1, OVERRUN=0.
- COUNT_WIDTH=4 build, INTERVAL=40, 20 pulses, DEAD_TIME=0: COUNT=15, SATURATED=1.
- Assert RST_N low mid-DEAD with COUNT_VALID=1: all outputs 0 immediately (async). After release, a pulse is accepted on the first TRIG_IN.
